alu_op_issue_stage: RTL and testbench
=====================================

// Module: alu_op_issue_stage
// PURPOSE
//  Producer side of the ALU Operation interface: decodes ALUOp/funct3/funct7 into the
//  4-bit ALU Operation code and issues it with operands SrcA/SrcB to the EX stage.
//  Sits between ID and the combinational ALU as a registered stage with valid/ready
//  handshake and a 2-entry skid buffer. Flags unsupported encodings as illegal.
// PARAMETERS
//  DATA_WIDTH     32  operand width (SrcA/SrcB)
//  OPCODE_LENGTH  4   width of Operation code driven to the ALU
// PORTS
//  clk         in   1           single clock, rising edge
//  rst_n       in   1           asynchronous reset, active-low
//  flush       in   1           sync pipeline flush (branch mispredict/trap)
//  in_valid    in   1           ID presents a decoded instruction
//  in_ready    out  1           stage can accept (registered)
//  ALUOp       in   2           00 mem/auipc, 01 branch, 10 R-type, 11 I-type ALU
//  Funct3      in   3           instruction funct3
//  Funct7      in   7           instruction funct7 (R-type only)
//  SrcA_in     in   DATA_WIDTH  operand A
//  SrcB_in     in   DATA_WIDTH  operand B (reg or imm, already muxed)
//  out_valid   out  1           EX entry valid
//  out_ready   in   1           EX consumes entry this cycle
//  Operation   out  OPCODE_LENGTH ALU operation code
//  SrcA        out  DATA_WIDTH  registered operand A
//  SrcB        out  DATA_WIDTH  registered operand B
//  illegal     out  1           entry's encoding unsupported
// BEHAVIOUR
//  - Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, EQ 1000.
//  - Decode: ALUOp 00 -> ADD. 01: f3 000/001 -> EQ, 100/101 -> SLT, 110/111 illegal.
//    10: f3 000 & f7 0000000 ADD, f3 000 & f7 0100000 SUB, 111 AND, 110 OR, 100 XOR,
//    010 SLT (f7 must be 0000000 for 111/110/100/010). 11: 000 ADD, 111 AND, 110 OR,
//    100 XOR, 010 SLT, f7 ignored. Anything else: Operation=ADD (0010), illegal=1.
//  - Transfer on in_valid&in_ready (accept) / out_valid&out_ready (consume).
//  - Latency 1: accepted beat appears on outputs next cycle when stage empty.
//  - Entries: main (drives outputs) + skid. in_ready = !skid_valid, registered.
//    Accept while main full and not consumed -> beat goes to skid, in_ready drops.
//    Consume with skid full -> skid moves to main, in_ready rises next cycle.
//    Accept + consume same cycle, skid empty -> main replaced; full throughput.
//  - Outputs stable (Operation, SrcA, SrcB, illegal) while out_valid & !out_ready.
//  - Order strictly preserved; no beat dropped or duplicated.
//  - flush: both entries invalidated next edge; beat offered same cycle is dropped;
//    flush wins over accept and consume. in_ready=1 after flush.
//  - Reset (async assert, sync deassert by parent): out_valid=0, in_ready=1,
//    Operation=0000, SrcA=0, SrcB=0, illegal=0, skid empty. Mid-transfer reset
//    discards all entries.
//  - Data regs of invalid entries keep last value except at reset.
// STRUCTURE
//  - alu_pkg: alu_op_e enum (codes above), ALUOP_* 2-bit constants,
//    F7_BASE=7'b0000000, F7_ALT=7'b0100000, function decode_alu_op().
//  - Sub-module: alu_skid_buffer #(WIDTH) holding {illegal,Operation,SrcA,SrcB};
//    top does combinational decode then feeds the buffer.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1, Operation=0000 at once.
//  2 ALUOp=10,f3=000,f7=0100000,A=7,B=3, out_ready=1 -> next cycle Operation=0110,
//    SrcA=7,SrcB=3,illegal=0; f7=0000000 -> 0010.
//  3 ALUOp=01,f3=100 -> 0111; f3=110 -> Operation=0010, illegal=1; ALUOp=10,f3=111,
//    f7=0100000 -> illegal=1.
//  4 Backpressure: out_ready=0, send beats A,B -> main=A, skid=B, in_ready=0;
//    out_ready=1 -> A then B on consecutive cycles, in_ready=1 after B moves.
//  5 Stream 8 beats, out_ready=1 -> one out per cycle, order preserved, no bubbles.
//  6 flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    offered beat never emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU operation issue stage: operation codes, ALUOp classes
// and the ALUOp/funct3/funct7 decoder used by the producer side of the ALU interface.
// Pure declarations; no ports, no state.
package alu_pkg;

  // 4-bit operation codes understood by the combinational ALU
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_EQ  = 4'b1000
  } alu_op_e;

  // ALUOp classes produced by the main decoder in ID
  localparam logic [1:0] ALUOP_MEM    = 2'b00;  // loads/stores/auipc: address add
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic    illegal;
    alu_op_e op;
  } alu_dec_t;

  // Unsupported encodings still produce ADD so the ALU sees a benign operation;
  // the illegal flag travels with the entry for the trap logic downstream.
  function automatic alu_dec_t decode_alu_op(input logic [1:0] alu_op,
                                             input logic [2:0] f3,
                                             input logic [6:0] f7);
    alu_dec_t res;
    res.illegal = 1'b1;
    res.op      = ALU_ADD;
    case (alu_op)
      ALUOP_MEM: begin
        res.illegal = 1'b0;
      end
      ALUOP_BRANCH: begin
        case (f3)
          3'b000, 3'b001: begin res.op = ALU_EQ;  res.illegal = 1'b0; end
          3'b100, 3'b101: begin res.op = ALU_SLT; res.illegal = 1'b0; end
          default: ;
        endcase
      end
      ALUOP_RTYPE: begin
        if (f3 == 3'b000 && f7 == F7_ALT) begin
          res.op      = ALU_SUB;
          res.illegal = 1'b0;
        end else if (f7 == F7_BASE) begin
          case (f3)
            3'b000: begin res.op = ALU_ADD; res.illegal = 1'b0; end
            3'b111: begin res.op = ALU_AND; res.illegal = 1'b0; end
            3'b110: begin res.op = ALU_OR;  res.illegal = 1'b0; end
            3'b100: begin res.op = ALU_XOR; res.illegal = 1'b0; end
            3'b010: begin res.op = ALU_SLT; res.illegal = 1'b0; end
            default: ;
          endcase
        end
      end
      default: begin  // ALUOP_ITYPE: funct7 is part of the immediate, ignored
        case (f3)
          3'b000: begin res.op = ALU_ADD; res.illegal = 1'b0; end
          3'b111: begin res.op = ALU_AND; res.illegal = 1'b0; end
          3'b110: begin res.op = ALU_OR;  res.illegal = 1'b0; end
          3'b100: begin res.op = ALU_XOR; res.illegal = 1'b0; end
          3'b010: begin res.op = ALU_SLT; res.illegal = 1'b0; end
          default: ;
        endcase
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_op_issue_stage_if.sv
// Bundle of the ID-facing and EX-facing handshake/data signals of the issue stage.
// master: the issue stage itself (consumes ID beats, produces ALU Operation entries).
// slave:  the environment around it (ID drives inputs, EX drives out_ready).
interface alu_op_issue_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  import alu_pkg::*;

  // ID side
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               ALUOp;
  logic [2:0]               Funct3;
  logic [6:0]               Funct7;
  logic [DATA_WIDTH-1:0]    SrcA_in;
  logic [DATA_WIDTH-1:0]    SrcB_in;

  // EX side
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic                     illegal;

  modport master (
    input  in_valid, ALUOp, Funct3, Funct7, SrcA_in, SrcB_in, out_ready,
    output in_ready, out_valid, Operation, SrcA, SrcB, illegal
  );

  modport slave (
    output in_valid, ALUOp, Funct3, Funct7, SrcA_in, SrcB_in, out_ready,
    input  in_ready, out_valid, Operation, SrcA, SrcB, illegal
  );

endinterface

// File: rtl/alu_skid_buffer.sv
// Two-entry (main + skid) registered buffer with valid/ready on both sides.
// Latency 1 when empty; full throughput with out_rdy held high.
// Backpressure: in_rdy = !skid valid, registered; flush empties both entries.
// Ports: clk, rst_n, flush | in_vld/in_rdy/in_dat | out_vld/out_rdy/out_dat.
module alu_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] main_dat_q, main_dat_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             accept;
  logic             consume;

  // in_rdy comes straight from a flop, so ID never sees a combinational path
  // from out_rdy.
  assign in_rdy  = !skid_vld_q;
  assign out_vld = main_vld_q;
  assign out_dat = main_dat_q;

  assign accept  = in_vld && !skid_vld_q;
  assign consume = main_vld_q && out_rdy;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_dat_d = main_dat_q;
    skid_dat_d = skid_dat_q;
    if (flush) begin
      // Data registers are left alone; only the valid bits are cleared.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // Skid only fills while main is held, so main is valid here and no
      // accept is possible; a consume promotes the skid entry.
      if (consume) begin
        main_dat_d = skid_dat_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end
    end else if (!main_vld_q || consume) begin
      main_vld_d = accept;
      if (accept) begin
        main_dat_d = in_dat;
      end
    end else if (accept) begin
      skid_dat_d = in_dat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_dat_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_dat_q <= main_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: rtl/alu_op_issue_stage.sv
// Decodes ALUOp/funct3/funct7 into the ALU operation code and issues it with SrcA/SrcB.
// Latency 1 cycle when empty; one entry per cycle sustained.
// Backpressure: 2-entry skid buffer, in_ready registered; flush drops everything.
// Ports: clk, rst_n (async, active-low), flush, bus (master view of the issue interface).
module alu_op_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  alu_op_issue_stage_if.master bus
);

  // Entry layout: {illegal, Operation, SrcA, SrcB}
  localparam int WIDTH = 1 + OPCODE_LENGTH + 2 * DATA_WIDTH;

  alu_dec_t                 dec;
  logic [OPCODE_LENGTH-1:0] op_code;
  logic [WIDTH-1:0]         in_dat;
  logic [WIDTH-1:0]         out_dat;

  always_comb dec = decode_alu_op(bus.ALUOp, bus.Funct3, bus.Funct7);

  assign op_code = OPCODE_LENGTH'(dec.op);
  assign in_dat  = {dec.illegal, op_code, bus.SrcA_in, bus.SrcB_in};

  alu_skid_buffer #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_vld  (bus.in_valid),
    .in_rdy  (bus.in_ready),
    .in_dat  (in_dat),
    .out_vld (bus.out_valid),
    .out_rdy (bus.out_ready),
    .out_dat (out_dat)
  );

  assign {bus.illegal, bus.Operation, bus.SrcA, bus.SrcB} = out_dat;

endmodule

// File: tb/tb_alu_op_issue_stage.sv
// Directed bench for alu_op_issue_stage: decode table plus hand-written
// sequences for reset, backpressure/skid, streaming and flush.
module tb_alu_op_issue_stage;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_issue_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_op_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_op;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.ALUOp    = aluop;
    bus.Funct3   = f3;
    bus.Funct7   = f7;
    bus.SrcA_in  = a;
    bus.SrcB_in  = b;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ALUOp     = 2'b00;
    bus.Funct3    = 3'b000;
    bus.Funct7    = 7'b0;
    bus.SrcA_in   = '0;
    bus.SrcB_in   = '0;

    //            aluop  f3      f7          A             B             op       ill
    vecs[0]  = '{2'b10, 3'b000, 7'b0100000, 32'd7,        32'd3,        4'b0110, 1'b0};
    vecs[1]  = '{2'b10, 3'b000, 7'b0000000, 32'd7,        32'd3,        4'b0010, 1'b0};
    vecs[2]  = '{2'b01, 3'b100, 7'b0000000, 32'h10,       32'h20,       4'b0111, 1'b0};
    vecs[3]  = '{2'b01, 3'b110, 7'b0000000, 32'h11,       32'h21,       4'b0010, 1'b1};
    vecs[4]  = '{2'b10, 3'b111, 7'b0100000, 32'h12,       32'h22,       4'b0010, 1'b1};
    vecs[5]  = '{2'b00, 3'b101, 7'b1111111, 32'hdeadbeef, 32'h12345678, 4'b0010, 1'b0};
    vecs[6]  = '{2'b01, 3'b000, 7'b0000000, 32'h1,        32'h1,        4'b1000, 1'b0};
    vecs[7]  = '{2'b01, 3'b001, 7'b0000000, 32'h2,        32'h3,        4'b1000, 1'b0};
    vecs[8]  = '{2'b01, 3'b101, 7'b0000000, 32'h4,        32'h5,        4'b0111, 1'b0};
    vecs[9]  = '{2'b01, 3'b111, 7'b0000000, 32'h6,        32'h7,        4'b0010, 1'b1};
    vecs[10] = '{2'b10, 3'b111, 7'b0000000, 32'hf0f0f0f0, 32'h0ff00ff0, 4'b0000, 1'b0};
    vecs[11] = '{2'b10, 3'b110, 7'b0000000, 32'h8,        32'h9,        4'b0001, 1'b0};
    vecs[12] = '{2'b10, 3'b100, 7'b0000000, 32'ha,        32'hb,        4'b0011, 1'b0};
    vecs[13] = '{2'b10, 3'b010, 7'b0000000, 32'hc,        32'hd,        4'b0111, 1'b0};
    vecs[14] = '{2'b10, 3'b001, 7'b0000000, 32'he,        32'hf,        4'b0010, 1'b1};
    vecs[15] = '{2'b10, 3'b000, 7'b0000001, 32'h13,       32'h14,       4'b0010, 1'b1};
    vecs[16] = '{2'b10, 3'b100, 7'b0100000, 32'h15,       32'h16,       4'b0010, 1'b1};
    vecs[17] = '{2'b11, 3'b000, 7'b0100000, 32'h17,       32'h18,       4'b0010, 1'b0};
    vecs[18] = '{2'b11, 3'b111, 7'b1010101, 32'h19,       32'h1a,       4'b0000, 1'b0};
    vecs[19] = '{2'b11, 3'b110, 7'b0000000, 32'h1b,       32'h1c,       4'b0001, 1'b0};
    vecs[20] = '{2'b11, 3'b100, 7'b0100000, 32'h1d,       32'h1e,       4'b0011, 1'b0};
    vecs[21] = '{2'b11, 3'b010, 7'b0000000, 32'h1f,       32'h20,       4'b0111, 1'b0};
    vecs[22] = '{2'b11, 3'b001, 7'b0000000, 32'h21,       32'h22,       4'b0010, 1'b1};
    vecs[23] = '{2'b11, 3'b101, 7'b0100000, 32'h23,       32'h24,       4'b0010, 1'b1};
    vecs[24] = '{2'b11, 3'b011, 7'b0000000, 32'h25,       32'h26,       4'b0010, 1'b1};
    vecs[25] = '{2'b00, 3'b000, 7'b0000000, 32'hffffffff, 32'h0,        4'b0010, 1'b0};

    // Reset values, observable without any clock edge
    #2;
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst in_ready",  bus.in_ready,  1'b1);
    chk("rst Operation", bus.Operation, 4'b0000);
    chk("rst SrcA",      bus.SrcA,      32'd0);
    chk("rst SrcB",      bus.SrcB,      32'd0);
    chk("rst illegal",   bus.illegal,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table: one beat at a time, checked one cycle after acceptance
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d Operation", i), bus.Operation, vecs[i].exp_op);
      chk($sformatf("vec%0d illegal", i),   bus.illegal,   vecs[i].exp_ill);
      chk($sformatf("vec%0d SrcA", i),      bus.SrcA,      vecs[i].a);
      chk($sformatf("vec%0d SrcB", i),      bus.SrcB,      vecs[i].b);
    end
    @(negedge clk);
    chk("drain out_valid", bus.out_valid, 1'b0);

    // Mid-transfer asynchronous reset discards the held entry immediately
    bus.out_ready = 1'b0;
    drive(ALUOP_RTYPE, 3'b000, F7_ALT, 32'd55, 32'd66);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("prerst out_valid", bus.out_valid, 1'b1);
    chk("prerst Operation", bus.Operation, 4'b0110);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", bus.out_valid, 1'b0);
    chk("midrst in_ready",  bus.in_ready,  1'b1);
    chk("midrst Operation", bus.Operation, 4'b0000);
    chk("midrst SrcA",      bus.SrcA,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure: A in main, B in skid, C offered while full must be refused
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(ALUOP_RTYPE, 3'b000, F7_ALT, 32'd7, 32'd3);        // A: SUB
    @(negedge clk);
    drive(ALUOP_ITYPE, 3'b111, 7'b0, 32'h11, 32'h22);         // B: AND
    @(negedge clk);
    drive(ALUOP_RTYPE, 3'b110, F7_BASE, 32'hc0c0, 32'hc1c1);  // C: refused
    chk("bp A out_valid", bus.out_valid, 1'b1);
    chk("bp A Operation", bus.Operation, 4'b0110);
    chk("bp A SrcA",      bus.SrcA,      32'd7);
    chk("bp A SrcB",      bus.SrcB,      32'd3);
    chk("bp in_ready low", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp hold Operation", bus.Operation, 4'b0110);
    chk("bp hold SrcA",      bus.SrcA,      32'd7);
    chk("bp hold in_ready",  bus.in_ready,  1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp B out_valid", bus.out_valid, 1'b1);
    chk("bp B Operation", bus.Operation, 4'b0000);
    chk("bp B SrcA",      bus.SrcA,      32'h11);
    chk("bp B SrcB",      bus.SrcB,      32'h22);
    chk("bp in_ready up", bus.in_ready,  1'b1);
    @(negedge clk);
    chk("bp C dropped", bus.out_valid, 1'b0);

    // Streaming: 8 back-to-back beats, each visible exactly one cycle later
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk($sformatf("stream%0d out_valid", i - 1), bus.out_valid, 1'b1);
        chk($sformatf("stream%0d SrcA", i - 1),      bus.SrcA,      32'h1000 + 32'(i - 1));
        chk($sformatf("stream%0d SrcB", i - 1),      bus.SrcB,      32'(3 * (i - 1)));
        chk($sformatf("stream%0d in_ready", i - 1),  bus.in_ready,  1'b1);
      end
      if (i < 8) drive(ALUOP_ITYPE, 3'b100, 7'b0, 32'h1000 + 32'(i), 32'(3 * i));
      else       bus.in_valid = 1'b0;
      @(negedge clk);
    end
    chk("stream end out_valid", bus.out_valid, 1'b0);

    // Flush with skid full and a beat offered in the same cycle
    bus.out_ready = 1'b0;
    drive(ALUOP_RTYPE, 3'b000, F7_ALT, 32'd7, 32'd3);
    @(negedge clk);
    drive(ALUOP_ITYPE, 3'b111, 7'b0, 32'h11, 32'h22);
    @(negedge clk);
    chk("fl pre in_ready", bus.in_ready, 1'b0);
    drive(ALUOP_ITYPE, 3'b110, 7'b0, 32'hdead, 32'hbeef);
    flush = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl out_valid",    bus.out_valid, 1'b0);
    chk("fl in_ready",     bus.in_ready,  1'b1);
    chk("fl kept SrcA",    bus.SrcA,      32'd7);
    chk("fl kept Op",      bus.Operation, 4'b0110);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("fl idle%0d out_valid", k), bus.out_valid, 1'b0);
    end

    // Flush on an empty stage drops the beat offered in that cycle
    drive(ALUOP_ITYPE, 3'b000, 7'b0, 32'h5555, 32'h6666);
    flush = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl2 out_valid", bus.out_valid, 1'b0);
    chk("fl2 in_ready",  bus.in_ready,  1'b1);
    chk("fl2 kept SrcA", bus.SrcA,      32'd7);
    @(negedge clk);
    chk("fl2 idle out_valid", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
